ctl_seq: RTL and testbench
==========================

CTL_SEQ -- requirements
Module: ctl_seq

Interface
REQ-001 Parameter WORD_LEN, default 64, register data width in bits (>= 32).
REQ-002 Parameter PC_LEN, default 32, program counter width in bits (>= 16).
REQ-003 clk_i  input  1  clock; all state updates on rising edge.
REQ-004 reset_i  input  1  reset, asynchronous and active-high.
REQ-005 inst_req_o  output  1  fetch request, high only in FETCH.
REQ-006 inst_valid_i  input  1  inst_i valid; an instruction is accepted on a cycle with inst_req_o & inst_valid_i.
REQ-007 inst_i  input  32  instruction word for address pc_o.
REQ-008 pc_o  output  PC_LEN  current fetch address.
REQ-009 reg_rd_id_o  output  reg_t  register read select; the register file returns data combinationally.
REQ-010 reg_value_i  input  WORD_LEN  read data for reg_rd_id_o.
REQ-011 reg_write_en_o  output  1  write strobe, one-cycle pulse.
REQ-012 reg_id_o  output  reg_t  write destination.
REQ-013 reg_value_o  output  WORD_LEN  write data.
REQ-014 halted_o  output  1  core halted.
REQ-015 illegal_o  output  1  one-cycle pulse on an undefined opcode.

Function
REQ-016 Instruction fields:
- opcode = [7:0]
- rd = [15:8]
- rs1 = [23:16]
- rs2 = [31:24]
- imm16 = [31:16]
REQ-017 FSM states: FETCH, DECODE, RD1, RD2, EXEC, HALT.
REQ-018 FETCH: on accept, latch inst_i and the fetch pc, set pc_o to pc_o+4 (modulo 2^PC_LEN), and go to DECODE; otherwise hold.
REQ-019 DECODE transitions:
- NOP: go to FETCH.
- HLT: go to HALT.
- IMOV: pulse a write of rd with zero-extended imm16 next cycle, then go to FETCH.
- MOV/ADD: go to RD1.
- Undefined opcode: pulse illegal_o and go to FETCH (acts as NOP).
REQ-020 RD1: drive reg_rd_id_o=rs1 and latch reg_value_i as operand A; go to RD2 for ADD, otherwise go to EXEC.
REQ-021 RD2: drive reg_rd_id_o=rs2, latch operand B, and go to EXEC.
REQ-022 EXEC:
- MOV writes A to rd.
- ADD writes (A+B) mod 2^WORD_LEN to rd; carry is discarded.
- Then go to FETCH.
REQ-023 Every write asserts reg_write_en_o for exactly one cycle, with reg_id_o/reg_value_o valid in that cycle; reg_id_o/reg_value_o hold their values afterwards.
REQ-024 Latencies from accept: NOP 2 cycles; IMOV 2; MOV 3; ADD 4 (each cycle count runs until the next inst_req_o).
REQ-025 HALT: halted_o=1, inst_req_o=0, pc_o frozen; HALT is exited only by reset.
REQ-026 inst_valid_i outside FETCH is ignored; no instruction is buffered.
REQ-027 reg_rd_id_o is 0 outside RD1/RD2.

Reset
REQ-028 Reset asserted in any state, including mid-instruction, forces the following immediately: state FETCH, pc_o=0, reg_write_en_o=0, reg_value_o=0, reg_id_o=0, reg_rd_id_o=0, halted_o=0, illegal_o=0, latched instruction/operands=0.
REQ-029 An in-flight write is dropped by reset and is never issued.
REQ-030 The first fetch is requested in the first cycle after reset deasserts.

Configuration
REQ-031 Macro CTL_SEQ_BRANCH_EN.
- When defined, two opcodes are added:
  - JMP: pc_o = fetch pc + sext(inst[31:8])*4, 2-cycle latency.
  - BEQZ: via RD1 reading rd; if A==0, pc_o = fetch pc + sext(imm16)*4, else pc_o is unchanged (sequential); 3-cycle latency.
- Branch arithmetic wraps modulo 2^PC_LEN.
REQ-032 When CTL_SEQ_BRANCH_EN is undefined, JMP/BEQZ encodings are undefined opcodes (REQ-019 applies).

Structure
REQ-033 The shared package holds:
- reg_t
- opcode constants (OPCODE_NOP, OPCODE_HLT, OPCODE_IMOV, OPCODE_MOV, OPCODE_ADD, OPCODE_JMP, OPCODE_BEQZ)
- the state enum ctl_state_t
REQ-034 One sub-module, ctl_seq_alu: combinational MOV/ADD result selection, WORD_LEN-parametrised.

Verification
REQ-035 IMOV rd=3 imm16=0x1234 -> reg_write_en_o pulses once 2 cycles after accept; reg_id_o=3, reg_value_o=0x1234; pc_o=4.
REQ-036 ADD rd=5 rs1=1 rs2=2, with regfile r1=0xFFFF_FFFF_FFFF_FFFF and r2=2 -> reg_rd_id_o=1 then 2; write r5=0x1 after 4 cycles.
REQ-037 HLT at pc 8, then inst_valid_i held high -> halted_o=1, inst_req_o=0, pc_o stays 12 for 20 cycles.
REQ-038 Opcode 0xEE -> single illegal_o pulse, no write, next fetch at pc+4.
REQ-039 Reset asserted in RD2 of an ADD -> outputs zero asynchronously, no write ever issued, fetch restarts at pc 0.
REQ-040 With CTL_SEQ_BRANCH_EN: JMP offset -1 at pc 16 -> next fetch at 12; BEQZ rd with r=0, imm16=2 at pc 0 -> next fetch at 8.

Source files
------------

// File: rtl/ctl_seq_pkg.sv
// ctl_seq_pkg: shared types and constants for the ctl_seq instruction sequencer.
//   reg_t        - register index (8-bit, matches the rd/rs1/rs2 instruction fields)
//   OPCODE_*     - opcode encodings (instruction bits [7:0])
//   ctl_state_t  - sequencer FSM state encoding
//   inst_t       - field view of a 32-bit instruction word
package ctl_seq_pkg;

  typedef logic [7:0] reg_t;

  localparam logic [7:0] OPCODE_NOP  = 8'h00;
  localparam logic [7:0] OPCODE_HLT  = 8'h01;
  localparam logic [7:0] OPCODE_IMOV = 8'h02;
  localparam logic [7:0] OPCODE_MOV  = 8'h03;
  localparam logic [7:0] OPCODE_ADD  = 8'h04;
  // Only decoded when CTL_SEQ_BRANCH_EN is defined; otherwise they are illegal.
  localparam logic [7:0] OPCODE_JMP  = 8'h05;
  localparam logic [7:0] OPCODE_BEQZ = 8'h06;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StRd1    = 3'd2,
    StRd2    = 3'd3,
    StExec   = 3'd4,
    StHalt   = 3'd5
  } ctl_state_t;

  // imm16 is {rs2, rs1}; JMP offset is {rs2, rs1, rd}.
  typedef struct packed {
    logic [7:0] rs2;
    logic [7:0] rs1;
    reg_t       rd;
    logic [7:0] opcode;
  } inst_t;

endpackage

// File: rtl/ctl_seq_if.sv
// ctl_seq_if: instruction-fetch and register-file bus of the ctl_seq sequencer.
//   Fetch:   inst_req_o, inst_valid_i, inst_i[31:0], pc_o[PC_LEN-1:0]
//   RF read: reg_rd_id_o (reg_t), reg_value_i[WORD_LEN-1:0] (combinational return)
//   RF wr:   reg_write_en_o, reg_id_o (reg_t), reg_value_o[WORD_LEN-1:0]
// Signal suffixes are from the sequencer's point of view.
//   master - the sequencer core
//   slave  - instruction memory / register file side
interface ctl_seq_if #(
  parameter int unsigned WORD_LEN = 64,
  parameter int unsigned PC_LEN   = 32
);
  import ctl_seq_pkg::*;

  logic                inst_req_o;
  logic                inst_valid_i;
  logic [31:0]         inst_i;
  logic [PC_LEN-1:0]   pc_o;
  reg_t                reg_rd_id_o;
  logic [WORD_LEN-1:0] reg_value_i;
  logic                reg_write_en_o;
  reg_t                reg_id_o;
  logic [WORD_LEN-1:0] reg_value_o;

  modport master (
    output inst_req_o,
    input  inst_valid_i,
    input  inst_i,
    output pc_o,
    output reg_rd_id_o,
    input  reg_value_i,
    output reg_write_en_o,
    output reg_id_o,
    output reg_value_o
  );

  modport slave (
    input  inst_req_o,
    output inst_valid_i,
    output inst_i,
    input  pc_o,
    input  reg_rd_id_o,
    output reg_value_i,
    input  reg_write_en_o,
    input  reg_id_o,
    input  reg_value_o
  );

endinterface

// File: rtl/ctl_seq_alu.sv
// ctl_seq_alu: combinational result selection for MOV/ADD.
//   op_add_i - 1: a_i + b_i (carry dropped), 0: pass a_i (MOV)
//   a_i, b_i - operands, WORD_LEN bits
//   result_o - write-back value, WORD_LEN bits
module ctl_seq_alu #(
  parameter int unsigned WORD_LEN = 64
) (
  input  logic                op_add_i,
  input  logic [WORD_LEN-1:0] a_i,
  input  logic [WORD_LEN-1:0] b_i,
  output logic [WORD_LEN-1:0] result_o
);

  always_comb begin
    result_o = a_i;
    if (op_add_i) begin
      result_o = a_i + b_i;
    end
  end

endmodule

// File: rtl/ctl_seq.sv
// ctl_seq: multi-cycle instruction sequencer (fetch, decode, operand read, write-back).
//   clk_i     - clock, rising edge
//   reset_i   - asynchronous active-high reset
//   bus_io    - ctl_seq_if.master: fetch handshake, register read and write ports
//   halted_o  - high while halted (left only by reset)
//   illegal_o - one-cycle pulse while decoding an undefined opcode
// Optional feature: define CTL_SEQ_BRANCH_EN to add JMP and BEQZ.
// Latency from accept to the next fetch request: NOP/IMOV/JMP 2, MOV/BEQZ 3, ADD 4.
module ctl_seq
  import ctl_seq_pkg::*;
#(
  parameter int unsigned WORD_LEN = 64,
  parameter int unsigned PC_LEN   = 32
) (
  input  logic      clk_i,
  input  logic      reset_i,
  ctl_seq_if.master bus_io,
  output logic      halted_o,
  output logic      illegal_o
);

  ctl_state_t          state_q, state_d;
  logic [PC_LEN-1:0]   pc_q, pc_d;
  inst_t               inst_q, inst_d;
  logic [WORD_LEN-1:0] op_a_q, op_a_d;
  logic                wr_en_q, wr_en_d;
  reg_t                wr_id_q, wr_id_d;
  logic [WORD_LEN-1:0] wr_val_q, wr_val_d;

  reg_t                rd_id;
  logic                illegal;
  logic                alu_add;
  logic [WORD_LEN-1:0] alu_a;
  logic [WORD_LEN-1:0] alu_res;

`ifdef CTL_SEQ_BRANCH_EN
  localparam int unsigned ExtW = (PC_LEN > 26) ? PC_LEN : 26;

  logic [PC_LEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [ExtW-1:0]   jmp_ext, beqz_ext;
  logic [PC_LEN-1:0] jmp_off, beqz_off;

  // Word offsets scaled to bytes, sign-extended then wrapped to the PC width.
  assign jmp_ext  = ExtW'($signed({inst_q[31:8], 2'b00}));
  assign beqz_ext = ExtW'($signed({inst_q[31:16], 2'b00}));
  assign jmp_off  = jmp_ext[PC_LEN-1:0];
  assign beqz_off = beqz_ext[PC_LEN-1:0];
`endif

  // Read select depends on state only, so the register file's combinational
  // return never loops back into this decision.
  always_comb begin
    rd_id = '0;
    unique case (state_q)
      StRd1: begin
        rd_id = inst_q.rs1;
`ifdef CTL_SEQ_BRANCH_EN
        if (inst_q.opcode == OPCODE_BEQZ) begin
          rd_id = inst_q.rd;
        end
`endif
      end
      StRd2:   rd_id = inst_q.rs2;
      default: rd_id = '0;
    endcase
  end

  // MOV passes the rs1 value read this cycle; ADD combines the latched A with rs2.
  always_comb begin
    alu_add = (state_q == StRd2);
    alu_a   = (state_q == StRd1) ? bus_io.reg_value_i : op_a_q;
  end

  ctl_seq_alu #(
    .WORD_LEN(WORD_LEN)
  ) u_alu (
    .op_add_i(alu_add),
    .a_i     (alu_a),
    .b_i     (bus_io.reg_value_i),
    .result_o(alu_res)
  );

  // Execution is folded into the last operand-read cycle: the write is
  // registered there and appears in the following FETCH cycle. StExec is
  // never entered and recovers to FETCH if it is ever seen.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    inst_d   = inst_q;
    op_a_d   = op_a_q;
    wr_en_d  = 1'b0;
    wr_id_d  = wr_id_q;
    wr_val_d = wr_val_q;
    illegal  = 1'b0;
`ifdef CTL_SEQ_BRANCH_EN
    fetch_pc_d = fetch_pc_q;
`endif

    unique case (state_q)
      StFetch: begin
        if (bus_io.inst_valid_i) begin
          inst_d  = bus_io.inst_i;
          pc_d    = pc_q + PC_LEN'(4);
          state_d = StDecode;
`ifdef CTL_SEQ_BRANCH_EN
          fetch_pc_d = pc_q;
`endif
        end
      end

      StDecode: begin
        case (inst_q.opcode)
          OPCODE_NOP: state_d = StFetch;
          OPCODE_HLT: state_d = StHalt;
          OPCODE_IMOV: begin
            wr_en_d  = 1'b1;
            wr_id_d  = inst_q.rd;
            wr_val_d = WORD_LEN'({inst_q.rs2, inst_q.rs1});
            state_d  = StFetch;
          end
          OPCODE_MOV, OPCODE_ADD: state_d = StRd1;
`ifdef CTL_SEQ_BRANCH_EN
          OPCODE_JMP: begin
            pc_d    = fetch_pc_q + jmp_off;
            state_d = StFetch;
          end
          OPCODE_BEQZ: state_d = StRd1;
`endif
          default: begin
            illegal = 1'b1;
            state_d = StFetch;
          end
        endcase
      end

      StRd1: begin
        op_a_d = bus_io.reg_value_i;
`ifdef CTL_SEQ_BRANCH_EN
        if (inst_q.opcode == OPCODE_BEQZ) begin
          if (bus_io.reg_value_i == '0) begin
            pc_d = fetch_pc_q + beqz_off;
          end
          state_d = StFetch;
        end else
`endif
        if (inst_q.opcode == OPCODE_ADD) begin
          state_d = StRd2;
        end else begin
          wr_en_d  = 1'b1;
          wr_id_d  = inst_q.rd;
          wr_val_d = alu_res;
          state_d  = StFetch;
        end
      end

      StRd2: begin
        wr_en_d  = 1'b1;
        wr_id_d  = inst_q.rd;
        wr_val_d = alu_res;
        state_d  = StFetch;
      end

      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= StFetch;
      pc_q     <= '0;
      inst_q   <= '0;
      op_a_q   <= '0;
      wr_en_q  <= 1'b0;
      wr_id_q  <= '0;
      wr_val_q <= '0;
`ifdef CTL_SEQ_BRANCH_EN
      fetch_pc_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      op_a_q   <= op_a_d;
      wr_en_q  <= wr_en_d;
      wr_id_q  <= wr_id_d;
      wr_val_q <= wr_val_d;
`ifdef CTL_SEQ_BRANCH_EN
      fetch_pc_q <= fetch_pc_d;
`endif
    end
  end

  assign bus_io.inst_req_o     = (state_q == StFetch);
  assign bus_io.pc_o           = pc_q;
  assign bus_io.reg_rd_id_o    = rd_id;
  assign bus_io.reg_write_en_o = wr_en_q;
  assign bus_io.reg_id_o       = wr_id_q;
  assign bus_io.reg_value_o    = wr_val_q;
  assign halted_o              = (state_q == StHalt);
  assign illegal_o             = illegal;

endmodule

// File: tb/tb_ctl_seq.sv
// tb_ctl_seq: directed, table-driven bench for ctl_seq with a behavioural register file.
// Honours CTL_SEQ_BRANCH_EN to select branch or illegal-opcode expectations.
module tb_ctl_seq;
  import ctl_seq_pkg::*;

  logic clk = 1'b0;
  logic reset_i;
  logic halted;
  logic illegal;

  always #5 clk = ~clk;

  ctl_seq_if #(.WORD_LEN(64), .PC_LEN(32)) bus ();

  ctl_seq #(
    .WORD_LEN(64),
    .PC_LEN  (32)
  ) dut (
    .clk_i    (clk),
    .reset_i  (reset_i),
    .bus_io   (bus),
    .halted_o (halted),
    .illegal_o(illegal)
  );

  // Register file model: combinational read, write on the clock edge, reloaded during reset.
  logic [63:0] regs [256];
  assign bus.reg_value_i = regs[bus.reg_rd_id_o];

  always @(posedge clk) begin
    if (reset_i) begin
      for (int i = 0; i < 256; i++) regs[i] <= '0;
      regs[1] <= 64'hFFFF_FFFF_FFFF_FFFF;
      regs[2] <= 64'd2;
      regs[7] <= 64'h1111_2222_3333_4444;
    end else if (bus.reg_write_en_o) begin
      regs[bus.reg_id_o] <= bus.reg_value_o;
    end
  end

  typedef struct {
    logic [31:0] inst;
    int          lat;
    int          n_wr;
    logic [7:0]  wid;
    logic [63:0] wval;
    int          n_ill;
    logic [31:0] pc;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  int n_run  = 0;
  int n_fail = 0;
  logic [7:0] rd_seen [0:16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Call while the DUT is in FETCH, away from a clock edge. Returns once the next
  // fetch request is seen (or after a 16-cycle bound).
  task automatic run_inst(input logic [31:0] instr, output int lat, output int n_wr,
                          output logic [7:0] wid, output logic [63:0] wval,
                          output int n_ill, output bit got_req);
    bus.inst_i       = instr;
    bus.inst_valid_i = 1'b1;
    @(posedge clk);
    #1;
    // Valid stays high with a HLT word: it must be ignored outside FETCH.
    bus.inst_i = 32'h0000_0001;
    lat = 0; n_wr = 0; n_ill = 0; wid = '0; wval = '0; got_req = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      rd_seen[c] = bus.reg_rd_id_o;
      if (bus.reg_write_en_o) begin
        n_wr++;
        wid  = bus.reg_id_o;
        wval = bus.reg_value_o;
      end
      if (illegal) n_ill++;
      if (bus.inst_req_o) begin
        lat     = c;
        got_req = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  int          lat, n_wr, n_ill, cnt_bad;
  logic [7:0]  wid;
  logic [63:0] wval;
  bit          got;

  initial begin
    reset_i          = 1'b1;
    bus.inst_valid_i = 1'b0;
    bus.inst_i       = '0;

    vecs[0] = '{32'h1234_0302, 2, 1, 8'd3,   64'h1234,                0, 32'd4};
    vecs[1] = '{32'h0201_0504, 4, 1, 8'd5,   64'h1,                   0, 32'd8};
    vecs[2] = '{32'h0000_0000, 2, 0, 8'd0,   64'h0,                   0, 32'd12};
    vecs[3] = '{32'h0007_0903, 3, 1, 8'd9,   64'h1111_2222_3333_4444, 0, 32'd16};
    vecs[4] = '{32'h0000_00EE, 2, 0, 8'd0,   64'h0,                   1, 32'd20};
    vecs[5] = '{32'h0503_0A04, 4, 1, 8'd10,  64'h1235,                0, 32'd24};
    vecs[6] = '{32'h0101_0B04, 4, 1, 8'd11,  64'hFFFF_FFFF_FFFF_FFFE, 0, 32'd28};
    vecs[7] = '{32'hFFFF_FF02, 2, 1, 8'd255, 64'hFFFF,                0, 32'd32};
`ifdef CTL_SEQ_BRANCH_EN
    vecs[8]  = '{32'hFFFF_FF05, 2, 0, 8'd0, 64'h0, 0, 32'd28};
    vecs[9]  = '{32'h0002_0406, 3, 0, 8'd0, 64'h0, 0, 32'd36};
    vecs[10] = '{32'h0002_0306, 3, 0, 8'd0, 64'h0, 0, 32'd40};
    vecs[11] = '{32'h0000_0305, 2, 0, 8'd0, 64'h0, 0, 32'd52};
`else
    vecs[8]  = '{32'hFFFF_FF05, 2, 0, 8'd0, 64'h0, 1, 32'd36};
    vecs[9]  = '{32'h0002_0406, 2, 0, 8'd0, 64'h0, 1, 32'd40};
    vecs[10] = '{32'h0002_0306, 2, 0, 8'd0, 64'h0, 1, 32'd44};
    vecs[11] = '{32'h0000_0305, 2, 0, 8'd0, 64'h0, 1, 32'd48};
`endif

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset pc", bus.pc_o, 0);
    chk("reset we", bus.reg_write_en_o, 0);
    chk("reset wid", bus.reg_id_o, 0);
    chk("reset wval", bus.reg_value_o, 0);
    chk("reset rd_id", bus.reg_rd_id_o, 0);
    chk("reset halted", halted, 0);
    chk("reset illegal", illegal, 0);
    reset_i = 1'b0;
    #1;
    chk("first fetch req", bus.inst_req_o, 1);

    // Table-driven instruction stream
    for (int i = 0; i < NVEC; i++) begin
      run_inst(vecs[i].inst, lat, n_wr, wid, wval, n_ill, got);
      chk($sformatf("vec%0d next fetch seen", i), got, 1);
      chk($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d writes", i), n_wr, vecs[i].n_wr);
      if (vecs[i].n_wr != 0) begin
        chk($sformatf("vec%0d wr id", i), wid, vecs[i].wid);
        chk($sformatf("vec%0d wr value", i), wval, vecs[i].wval);
      end
      chk($sformatf("vec%0d illegal pulses", i), n_ill, vecs[i].n_ill);
      chk($sformatf("vec%0d pc", i), bus.pc_o, vecs[i].pc);
    end

    // ADD read-select sequence: DECODE 0, RD1 rs1, RD2 rs2, FETCH 0
    run_inst(32'h0201_0504, lat, n_wr, wid, wval, n_ill, got);
    chk("add rd_id decode", rd_seen[1], 0);
    chk("add rd_id rd1", rd_seen[2], 1);
    chk("add rd_id rd2", rd_seen[3], 2);
    chk("add rd_id fetch", rd_seen[4], 0);
    chk("add write value", wval, 64'h1);

    // Reset during RD2 of an ADD: write dropped, outputs cleared at once
    bus.inst_i       = 32'h0201_0C04;
    bus.inst_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.inst_i = 32'h0000_0001;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midreset in rd2", bus.reg_rd_id_o, 2);
    #2;
    reset_i          = 1'b1;
    bus.inst_valid_i = 1'b0;
    #1;
    chk("midreset we", bus.reg_write_en_o, 0);
    chk("midreset wval", bus.reg_value_o, 0);
    chk("midreset wid", bus.reg_id_o, 0);
    chk("midreset rd_id", bus.reg_rd_id_o, 0);
    chk("midreset pc", bus.pc_o, 0);
    cnt_bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (bus.reg_write_en_o) cnt_bad++;
    end
    @(negedge clk);
    reset_i = 1'b0;
    #1;
    chk("post reset fetch req", bus.inst_req_o, 1);
    chk("post reset pc", bus.pc_o, 0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (bus.reg_write_en_o) cnt_bad++;
    end
    chk("dropped write never issued", cnt_bad, 0);
    chk("pc holds without valid", bus.pc_o, 0);

    // HLT at pc 8 with valid held high afterwards
    run_inst(32'h0000_0000, lat, n_wr, wid, wval, n_ill, got);
    run_inst(32'h0000_0000, lat, n_wr, wid, wval, n_ill, got);
    chk("pre-halt pc", bus.pc_o, 8);
    bus.inst_i       = 32'h0000_0001;
    bus.inst_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.inst_i = 32'h0000_0000;
    cnt_bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (halted !== 1'b1 || bus.inst_req_o !== 1'b0 || bus.pc_o !== 32'd12 ||
          bus.reg_write_en_o !== 1'b0 || illegal !== 1'b0) cnt_bad++;
    end
    chk("halt cycles wrong", cnt_bad, 0);
    chk("halted", halted, 1);
    chk("halt pc", bus.pc_o, 12);
    reset_i = 1'b1;
    #1;
    chk("halt left by reset", halted, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    #1;

`ifdef CTL_SEQ_BRANCH_EN
    // BEQZ taken at pc 0, then JMP -1 at pc 16
    run_inst(32'h0002_0406, lat, n_wr, wid, wval, n_ill, got);
    chk("beqz latency", lat, 3);
    chk("beqz taken pc", bus.pc_o, 8);
    run_inst(32'h0000_0000, lat, n_wr, wid, wval, n_ill, got);
    run_inst(32'h0000_0000, lat, n_wr, wid, wval, n_ill, got);
    chk("pre-jmp pc", bus.pc_o, 16);
    run_inst(32'hFFFF_FF05, lat, n_wr, wid, wval, n_ill, got);
    chk("jmp latency", lat, 2);
    chk("jmp back pc", bus.pc_o, 12);
    chk("jmp no write", n_wr, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
